// File: rtl/mx_rcvr_frame_ctrl.sv
// Frame-level receive controller behind the Manchester receiver.
// Buffers one carrier burst per frame and hands good frames to a reader.
module mx_rcvr_frame_ctrl #(
    parameter  int MAX_BYTES = 32,
    parameter  int MIN_BYTES = 1,
    localparam int LW        = $clog2(MAX_BYTES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cardet,
    input  logic          write,
    input  logic          error,
    input  logic [7:0]    data,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          frame_err,
    output logic          frame_drop,
    output logic          busy,
    output logic [15:0]   good_cnt
);

    localparam int            AW    = LW - 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAX_BYTES);
    localparam logic [LW-1:0] MIN_L = LW'(MIN_BYTES);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        HOLD
    } state_t;

    state_t        state;
    logic          cardet_q;
    logic          cd_init;
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [7:0]    mem [MAX_BYTES];

    logic          cd_rise;
    logic          cd_fall;
    logic          ovf;
    logic          wr_ok;
    logic          wr_en;
    logic [LW-1:0] wr_next;
    logic          rd_ok;
    logic          rd_last;

    // Carrier edges and the accept/advance decisions for this cycle.
    // cd_init masks a carrier that is already high when reset releases.
    always_comb begin
        cd_rise = cardet & ~cardet_q & cd_init;
        cd_fall = ~cardet & cardet_q;
        ovf     = write & (wr_ptr == MAX_L);
        wr_ok   = write & ~error & ~ovf;
        wr_en   = (state == RECV) & wr_ok;
        wr_next = wr_ok ? wr_ptr + ONE_L : wr_ptr;
        rd_ok   = rd_en & (rd_ptr < frame_len);
        rd_last = rd_ptr == (frame_len - ONE_L);
    end

    // Carrier history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cardet_q <= 1'b0;
            cd_init  <= 1'b0;
        end else begin
            cardet_q <= cardet;
            cd_init  <= 1'b1;
        end
    end

    // Frame buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    // Frame sequencer with registered outputs and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
            frame_err   <= 1'b0;
            frame_drop  <= 1'b0;
            busy        <= 1'b0;
            good_cnt    <= 16'h0000;
        end else begin
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
            rd_valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cd_rise) begin
                        state  <= RECV;
                        wr_ptr <= '0;
                        busy   <= 1'b1;
                    end
                end
                RECV: begin
                    if (error || ovf) begin
                        frame_err <= 1'b1;
                        state     <= DROP;
                    end else begin
                        wr_ptr <= wr_next;
                        if (cd_fall) begin
                            busy <= 1'b0;
                            if (wr_next >= MIN_L) begin
                                state       <= HOLD;
                                frame_valid <= 1'b1;
                                frame_len   <= wr_next;
                                good_cnt    <= good_cnt + 16'd1;
                                rd_ptr      <= '0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!cardet) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cd_rise) begin
                        frame_drop <= 1'b1;
                    end
                    if (rd_ok) begin
                        rd_data  <= mem[rd_ptr[AW-1:0]];
                        rd_valid <= 1'b1;
                        rd_ptr   <= rd_ptr + ONE_L;
                        if (rd_last) begin
                            frame_valid <= 1'b0;
                            if (cardet) begin
                                state <= DROP;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
